// File: rtl/dcache_axi_if.sv
// AXI4 master bridge for the data cache: line refill/write-back bursts
// and uncached single-beat accesses, one outstanding request at a time.
module dcache_axi_if #(
    parameter logic [3:0] ID         = 4'd1,
    parameter int         LINE_WORDS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       axi_rreq_i,
    input  logic                       axi_wreq_i,
    input  logic                       uc_rreq_i,
    input  logic                       uc_wreq_i,
    input  logic [31:0]                addr_i,
    input  logic [3:0]                 bus_wen_i,
    input  logic [31:0]                uc_wdata_i,
    input  logic [32*LINE_WORDS-1:0]   wb_line_i,
    output logic                       rend_o,
    output logic                       wend_o,
    output logic [32*LINE_WORDS-1:0]   line_rdata_o,
    output logic [31:0]                uc_rdata_o,
    output logic                       busy_o,
    output logic [3:0]                 arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [31:0]                rdata,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready,
    output logic [3:0]                 awid,
    output logic [31:0]                awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [31:0]                wdata,
    output logic [3:0]                 wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic                       bvalid,
    output logic                       bready
);

    localparam int CW = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B
    } state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q;
    logic [31:0]                   addr_q;
    logic                          uc_q;
    logic [3:0]                    strb_q;
    logic [31:0]                   uc_wdata_q;
    logic [LINE_WORDS-1:0][31:0]   wb_q;
    logic [LINE_WORDS-1:0][31:0]   line_q;
    logic                          any_req;
    logic                          rd_sel;
    logic                          accept;

    assign any_req = uc_rreq_i | uc_wreq_i | axi_rreq_i | axi_wreq_i;
    assign rd_sel  = uc_rreq_i | (~uc_wreq_i & axi_rreq_i);
    assign accept  = (state_q == S_IDLE) & any_req & ~rend_o & ~wend_o;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = rd_sel ? S_AR : S_AW;
            S_AR:   if (arready) state_d = S_R;
            S_R:    if (rvalid && rlast) state_d = S_IDLE;
            S_AW:   if (awready) state_d = S_W;
            S_W:    if (wready && wlast) state_d = S_B;
            S_B:    if (bvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            uc_q       <= 1'b0;
            strb_q     <= '0;
            uc_wdata_q <= '0;
            wb_q       <= '0;
            line_q     <= '0;
            uc_rdata_o <= '0;
            rend_o     <= 1'b0;
            wend_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            rend_o  <= (state_q == S_R) && rvalid && rlast;
            wend_o  <= (state_q == S_B) && bvalid;
            if (state_q == S_IDLE) cnt_q <= '0;
            // uc flag is exact: a read is only picked over uc_wreq when uc_rreq is set
            if (accept) begin
                addr_q     <= addr_i;
                uc_q       <= uc_rreq_i | uc_wreq_i;
                strb_q     <= bus_wen_i;
                uc_wdata_q <= uc_wdata_i;
                wb_q       <= wb_line_i;
            end
            if (state_q == S_R && rvalid) begin
                if (uc_q) uc_rdata_o <= rdata;
                else      line_q[cnt_q] <= rdata;
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == S_W && wready) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign line_rdata_o = line_q;
    assign busy_o       = (state_q != S_IDLE);

    assign arid    = ID;
    assign araddr  = addr_q;
    assign arlen   = uc_q ? 8'd0 : 8'(LINE_WORDS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arvalid = (state_q == S_AR);
    assign rready  = (state_q == S_R);

    assign awid    = ID;
    assign awaddr  = addr_q;
    assign awlen   = uc_q ? 8'd0 : 8'(LINE_WORDS - 1);
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awvalid = (state_q == S_AW);

    assign wvalid  = (state_q == S_W);
    assign wdata   = uc_q ? uc_wdata_q : wb_q[cnt_q];
    assign wstrb   = uc_q ? strb_q : 4'hF;
    assign wlast   = wvalid & (uc_q | (cnt_q == LAST));
    assign bready  = (state_q == S_B);

endmodule

// File: tb/tb_dcache_axi_if.sv
// Directed bench for dcache_axi_if: refill, uncached read/write,
// write-back with wready stalls, priority and mid-burst reset.
module tb_dcache_axi_if;

    logic         clk = 1'b0;
    logic         rst;
    logic         axi_rreq_i, axi_wreq_i, uc_rreq_i, uc_wreq_i;
    logic [31:0]  addr_i;
    logic [3:0]   bus_wen_i;
    logic [31:0]  uc_wdata_i;
    logic [255:0] wb_line_i;
    logic         rend_o, wend_o, busy_o;
    logic [255:0] line_rdata_o;
    logic [31:0]  uc_rdata_o;
    logic [3:0]   arid, awid;
    logic [31:0]  araddr, awaddr, rdata, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready;
    logic [3:0]   wstrb;
    logic         wlast, wvalid, wready, bvalid, bready;

    int total = 0;
    int fails = 0;

    dcache_axi_if dut (
        .clk(clk), .rst(rst),
        .axi_rreq_i(axi_rreq_i), .axi_wreq_i(axi_wreq_i),
        .uc_rreq_i(uc_rreq_i), .uc_wreq_i(uc_wreq_i),
        .addr_i(addr_i), .bus_wen_i(bus_wen_i),
        .uc_wdata_i(uc_wdata_i), .wb_line_i(wb_line_i),
        .rend_o(rend_o), .wend_o(wend_o),
        .line_rdata_o(line_rdata_o), .uc_rdata_o(uc_rdata_o),
        .busy_o(busy_o),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int k);
        return line_rdata_o[k*32 +: 32];
    endfunction

    // Zero-wait refill; word k returns base*(k+1)
    task automatic refill(input logic [31:0] a, input logic [31:0] base);
        axi_rreq_i = 1'b1;
        addr_i     = a;
        step();
        axi_rreq_i = 1'b0;
        addr_i     = 32'h0;
        check("ref_arvalid", arvalid, 1'b1);
        check("ref_araddr", araddr, a);
        check("ref_arlen", arlen, 8'd7);
        check("ref_arburst", arburst, 2'b01);
        check("ref_arsize", arsize, 3'b010);
        check("ref_arid", arid, 4'd1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("ref_rready", rready, 1'b1);
        check("ref_arvalid_drop", arvalid, 1'b0);
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1;
            rdata  = base * (k + 1);
            rlast  = (k == 7);
            check("ref_no_early_rend", rend_o, 1'b0);
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        check("ref_rend", rend_o, 1'b1);
        check("ref_idle", busy_o, 1'b0);
        check("ref_word0", word(0), base);
        check("ref_word3", word(3), base * 4);
        check("ref_word7", word(7), base * 8);
        step();
        check("ref_rend_single", rend_o, 1'b0);
    endtask

    initial begin
        int n;
        int beats;
        logic [255:0] wb;

        rst = 1'b1;
        {axi_rreq_i, axi_wreq_i, uc_rreq_i, uc_wreq_i} = 4'b0;
        addr_i = 0; bus_wen_i = 0; uc_wdata_i = 0; wb_line_i = 0;
        arready = 0; rdata = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bvalid = 0;
        step();
        step();
        check("rst_busy", busy_o, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_rend", rend_o, 1'b0);
        check("rst_wend", wend_o, 1'b0);
        check("rst_line", line_rdata_o, 256'h0);
        check("rst_uc", uc_rdata_o, 32'h0);
        rst = 1'b0;
        step();

        // Line refill at 0x1FC0_0020, beats 0x11..0x88
        refill(32'h1FC0_0020, 32'h11);

        // Uncached read, arready delayed 3 cycles
        uc_rreq_i = 1'b1;
        addr_i    = 32'hBFAF_8004;
        step();
        uc_rreq_i = 1'b0;
        addr_i    = 32'h0;
        check("ucr_arlen", arlen, 8'd0);
        check("ucr_araddr", araddr, 32'hBFAF_8004);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (arvalid) n++;
            arready = (i == 3);
            step();
        end
        arready = 1'b0;
        check("ucr_arvalid_cycles", n, 4);
        check("ucr_rready", rready, 1'b1);
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rlast = 1'b1;
        step();
        rvalid = 1'b0; rlast = 1'b0;
        check("ucr_rend", rend_o, 1'b1);
        check("ucr_data", uc_rdata_o, 32'hDEADBEEF);
        check("ucr_line_kept", word(0), 32'h11);
        step();
        check("ucr_rend_single", rend_o, 1'b0);
        check("ucr_data_hold", uc_rdata_o, 32'hDEADBEEF);

        // Uncached write, strobes 0011
        uc_wreq_i  = 1'b1;
        addr_i     = 32'hBFAF_8010;
        bus_wen_i  = 4'b0011;
        uc_wdata_i = 32'h0000_ABCD;
        step();
        uc_wreq_i  = 1'b0;
        bus_wen_i  = 4'b1111;
        uc_wdata_i = 32'hFFFF_FFFF;
        check("ucw_awvalid", awvalid, 1'b1);
        check("ucw_awaddr", awaddr, 32'hBFAF_8010);
        check("ucw_awlen", awlen, 8'd0);
        awready = 1'b1;
        step();
        awready = 1'b0;
        check("ucw_awvalid_drop", awvalid, 1'b0);
        check("ucw_wvalid", wvalid, 1'b1);
        check("ucw_wdata", wdata, 32'h0000_ABCD);
        check("ucw_wstrb", wstrb, 4'b0011);
        check("ucw_wlast", wlast, 1'b1);
        wready = 1'b1;
        step();
        wready = 1'b0;
        check("ucw_wvalid_drop", wvalid, 1'b0);
        check("ucw_bready", bready, 1'b1);
        step();
        bvalid = 1'b1;
        check("ucw_no_early_wend", wend_o, 1'b0);
        step();
        bvalid = 1'b0;
        check("ucw_wend", wend_o, 1'b1);
        step();
        check("ucw_wend_single", wend_o, 1'b0);
        check("ucw_idle", busy_o, 1'b0);

        // Line write-back with wready toggling
        for (int k = 0; k < 8; k++) wb[k*32 +: 32] = 32'hA000_0000 + k;
        axi_wreq_i = 1'b1;
        addr_i     = 32'h0000_1000;
        wb_line_i  = wb;
        step();
        axi_wreq_i = 1'b0;
        wb_line_i  = 256'h0;
        check("wb_awlen", awlen, 8'd7);
        check("wb_awburst", awburst, 2'b01);
        check("wb_awid", awid, 4'd1);
        awready = 1'b1;
        step();
        awready = 1'b0;
        beats = 0;
        for (int c = 0; c < 40 && beats < 8; c++) begin
            wready = c[0];
            if (wvalid && wready) begin
                check("wb_wdata", wdata, wb[beats*32 +: 32]);
                check("wb_wlast", wlast, beats == 7);
                check("wb_wstrb", wstrb, 4'hF);
                beats++;
            end
            step();
        end
        wready = 1'b0;
        check("wb_beats", beats, 8);
        check("wb_bready", bready, 1'b1);
        step();
        check("wb_b_wait", bready, 1'b1);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        check("wb_wend", wend_o, 1'b1);
        step();
        check("wb_wend_single", wend_o, 1'b0);

        // Priority: uncached read beats line refill, refill follows
        uc_rreq_i  = 1'b1;
        axi_rreq_i = 1'b1;
        addr_i     = 32'h0000_2000;
        step();
        uc_rreq_i = 1'b0;
        check("pri_uc_first", arlen, 8'd0);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h1234_5678; rlast = 1'b1;
        step();
        rvalid = 1'b0; rlast = 1'b0;
        check("pri_rend", rend_o, 1'b1);
        check("pri_uc_data", uc_rdata_o, 32'h1234_5678);
        check("pri_not_on_pulse", busy_o, 1'b0);
        step();
        check("pri_accept_cycle", arvalid, 1'b0);
        step();
        axi_rreq_i = 1'b0;
        check("pri_refill_ar", arvalid, 1'b1);
        check("pri_refill_len", arlen, 8'd7);
        arready = 1'b1;
        step();
        arready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1; rdata = 32'h100 + k; rlast = (k == 7);
            step();
        end
        rvalid = 1'b0; rlast = 1'b0;
        check("pri_refill_rend", rend_o, 1'b1);
        check("pri_refill_w5", word(5), 32'h105);
        check("pri_uc_kept", uc_rdata_o, 32'h1234_5678);
        step();

        // Reset during R beat 4
        axi_rreq_i = 1'b1;
        addr_i     = 32'h0000_3000;
        step();
        axi_rreq_i = 1'b0;
        arready = 1'b1;
        step();
        arready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rvalid = 1'b1; rdata = 32'h500 + k; rlast = 1'b0;
            rst = (k == 4);
            step();
        end
        rst = 1'b0;
        rvalid = 1'b0;
        check("rst_mid_idle", busy_o, 1'b0);
        check("rst_mid_rready", rready, 1'b0);
        check("rst_mid_rend", rend_o, 1'b0);
        check("rst_mid_arvalid", arvalid, 1'b0);
        step();
        check("rst_mid_rend2", rend_o, 1'b0);
        refill(32'h0000_4000, 32'h0101_0101);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/dcache_axi_if.md
# dcache_axi_if

AXI4 master-side bridge for the data cache. It accepts one outstanding request at a time from dcache stage 2: a cached line refill, a line write-back, an uncached read, or an uncached write. It runs the matching AXI4 burst or single-beat transaction and returns `rend`/`wend` completion pulses, with the 256-bit refill line or the 32-bit uncached read data. It sits between `dcache_s2` and the AXI crossbar.

## Interface
- `ID`, 4'd1, fixed value driven on `arid`/`awid`.
- `LINE_WORDS`, 8, words per cache line (bursts use `LINE_WORDS-1` as len).
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `axi_rreq_i` in 1: cached line refill request.
- `axi_wreq_i` in 1: dirty line write-back request.
- `uc_rreq_i` in 1: uncached single-word read.
- `uc_wreq_i` in 1: uncached single-word write.
- `addr_i` in 32: request address. Line-aligned for line requests; word address for uncached requests.
- `bus_wen_i` in 4: byte strobes for uncached write.
- `uc_wdata_i` in 32: uncached write data.
- `wb_line_i` in 256: write-back line; word 0 = [31:0].
- `rend_o` out 1: one-cycle read-complete pulse.
- `wend_o` out 1: one-cycle write-complete pulse.
- `line_rdata_o` out 256: refilled line; word k at [32k+31:32k].
- `uc_rdata_o` out 32: uncached read data.
- `busy_o` out 1: FSM not IDLE.
- AXI AR: `arid`[3:0], `araddr`[31:0], `arlen`[7:0], `arsize`[2:0], `arburst`[1:0], `arvalid` out; `arready` in.
- AXI R: `rdata`[31:0], `rlast`, `rvalid` in; `rready` out. `rresp` and `rid` are ignored.
- AXI AW: `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awvalid` out; `awready` in.
- AXI W: `wdata`[31:0], `wstrb`[3:0], `wlast`, `wvalid` out; `wready` in.
- AXI B: `bvalid` in; `bready` out. `bresp` is ignored.

## Operation
- States: IDLE, AR, R, AW, W, B.
- Requests are sampled only in IDLE, and not in a cycle where `rend_o` or `wend_o` is high.
- Acceptance priority: `uc_rreq_i` > `uc_wreq_i` > `axi_rreq_i` > `axi_wreq_i`.
- At acceptance, the bridge latches address, kind, strobes, `uc_wdata_i` and `wb_line_i`. Inputs are don't-care afterwards.
- Reads: IDLE→AR.
  - `araddr` = latched address.
  - Line read: `arlen`=LINE_WORDS-1, `arburst`=INCR (2'b01).
  - Uncached read: `arlen`=0, `arburst`=INCR.
  - `arsize`=3'b010 always.
  - `arvalid` is held until `arready`, then the FSM moves to R.
- R state:
  - `rready`=1.
  - A beat counter (3 bits, cleared on entry) steers each accepted `rdata` into line word [cnt]. Uncached reads write `uc_rdata_o`.
  - On the beat with `rlast`: FSM→IDLE and `rend_o` pulses next cycle.
  - If the counter wraps before `rlast`, the extra beats overwrite from word 0. Completion is decided by `rlast` alone.
- Writes: IDLE→AW.
  - `awlen` and `awburst` follow the same rules as AR.
  - `awvalid` is held until `awready`, then the FSM moves to W. AW and W are never concurrent.
- W state:
  - `wvalid`=1.
  - `wdata` = line word [cnt] (uncached: `uc_wdata_i` latch).
  - `wstrb` = 4'hF for a line write, latched `bus_wen_i` for uncached.
  - `wlast` = (cnt==LINE_WORDS-1) for a line write, 1 for uncached.
  - cnt advances on each `wready` handshake. The `wlast` handshake moves the FSM to B.
- B state: `bready`=1. A `bvalid` handshake sends the FSM to IDLE and `wend_o` pulses next cycle.
- `line_rdata_o` and `uc_rdata_o` hold their values until overwritten by a later read. They stay valid while `rend_o` is high and afterwards.

## Timing
- Reset values:
  - state IDLE.
  - All `*valid`, `rready`, `bready`, `wlast`, `rend_o`, `wend_o`, `busy_o` = 0.
  - `line_rdata_o` = 0, `uc_rdata_o` = 0, counter = 0.
- Reset asserted mid-transaction returns the bridge to IDLE on the next edge and drops all valids. The whole system is reset together.
- Outputs are registered. `arvalid`/`awvalid` rise the cycle after acceptance.
- Line refill with zero-wait slave, accept at cycle 0: AR at 1, beats at 2–9, `rend_o` at 10. Uncached read: `rend_o` at 3.
- Line write-back with zero-wait slave and `bvalid` at cycle 10: `wend_o` at 11. Uncached write: `wend_o` at 5 when B returns at 4.
- Back-to-back: a request held through the end pulse is accepted the cycle after `rend_o`/`wend_o`.
- Slave stalls (`arready`/`awready`/`wready` low, `rvalid`/`bvalid` gaps) extend their state only. No beat is lost or duplicated.

## Test plan
- Line refill at 0x1FC0_0020, R beats 0x11..0x88 with zero wait → `arlen`=7, `arburst`=01; `rend_o` at cycle 10; `line_rdata_o`[31:0]=0x11 and [255:224]=0x88.
- Uncached read at 0xBFAF_8004 with `arready` delayed 3 cycles, `rdata`=0xDEADBEEF → `arvalid` held 4 cycles, `arlen`=0, `uc_rdata_o`=0xDEADBEEF, single `rend_o` pulse.
- Uncached write, `bus_wen_i`=4'b0011, data 0x0000_ABCD → one W beat with `wstrb`=0011, `wlast`=1; `wend_o` one cycle after `bvalid`.
- Line write-back with `wready` toggling every other cycle → 8 beats in order word0..word7, `wlast` only on beat 7, `wend_o` once.
- `uc_rreq_i` and `axi_rreq_i` both high in IDLE → uncached read is served first. With `axi_rreq_i` still held, the line refill starts the cycle after `rend_o`.
- `rst` asserted during R beat 4 → next cycle state IDLE, `rready`=0, no `rend_o`. A fresh refill then completes normally.
